// File: rtl/obc_dft_pkg.sv
// Shared defaults and FSM state encoding for the OBC distributed-arithmetic DFT sequencer.
package obc_dft_pkg;

    localparam int SAMP_W_DEF = 12;
    localparam int N_PTS_DEF  = 16;
    localparam int ACC_W_DEF  = 32;
    localparam int BIN_W      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        OUT     = 2'd3
    } dft_state_e;

endpackage

// File: rtl/obc_shift_acc.sv
// Bit-serial shift-accumulate datapath: halves (acc + rom_sum) per bit, and on the
// sign bit subtracts the partial sum and adds the OBC offset to form the bin result.
module obc_shift_acc
    import obc_dft_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step,
    input  logic             fin,
    input  logic [ACC_W-1:0] rom_sum,
    input  logic [ACC_W-1:0] offset,
    output logic [ACC_W-1:0] out_data
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] out_data_r;

    // Sum is formed one bit wider so the shift keeps the true sign before truncation.
    function automatic logic [ACC_W-1:0] half_sum(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        return s[ACC_W:1];
    endfunction

    // Accumulator: cleared at each bin start, advanced once per non-sign bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (step) begin
            acc_r <= half_sum(acc_r, rom_sum);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result register: sign-bit weight is negative in two's complement; wraps silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_r <= {ACC_W{1'b0}};
        end else if (fin) begin
            out_data_r <= acc_r - rom_sum + offset;
        end else begin
            out_data_r <= out_data_r;
        end
    end

    assign out_data = out_data_r;

endmodule

// File: rtl/obc_dft_sequencer.sv
// Frame sequencer for an offset-binary-coded DA DFT: loads a sample frame, walks the
// external ROM network bit-serially per bin, and hands out one result per bin.
module obc_dft_sequencer
    import obc_dft_pkg::*;
#(
    parameter int SAMP_W = SAMP_W_DEF,
    parameter int N_PTS  = N_PTS_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ACC_W-1:0]  offset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SAMP_W-1:0] in_data,
    output logic [N_PTS-1:0]  slice,
    output logic [BIN_W-1:0]  bin_idx,
    input  logic [ACC_W-1:0]  rom_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [BIN_W-1:0]  out_bin,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W = $clog2(SAMP_W);
    localparam int CNT_W = $clog2(N_PTS);

    dft_state_e        state_r, state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [BIT_W-1:0]  bit_r;
    logic [BIN_W-1:0]  bin_r;
    logic [BIN_W-1:0]  out_bin_r;
    logic [ACC_W-1:0]  offset_r;
    logic [SAMP_W-1:0] samples_r [N_PTS];
    logic              in_ready_r, busy_r, out_valid_r, done_r;
    logic              start_s, load_s, first_s, clr_s, step_s, fin_s, next_bin_s, last_s;
    logic [N_PTS-1:0]  slice_s;

    // Next-state and control strobes.
    always_comb begin
        state_s    = state_r;
        start_s    = 1'b0;
        load_s     = 1'b0;
        first_s    = 1'b0;
        clr_s      = 1'b0;
        step_s     = 1'b0;
        fin_s      = 1'b0;
        next_bin_s = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // done_r blocks a start that coincides with the end-of-frame pulse
                if (start && !done_r) begin
                    start_s = 1'b1;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    load_s = 1'b1;
                    if (cnt_r == CNT_W'(N_PTS - 1)) begin
                        first_s = 1'b1;
                        clr_s   = 1'b1;
                        state_s = COMPUTE;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            COMPUTE: begin
                if (bit_r == BIT_W'(SAMP_W - 1)) begin
                    fin_s   = 1'b1;
                    state_s = OUT;
                end else begin
                    step_s  = 1'b1;
                    state_s = COMPUTE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (bin_r == BIN_W'(N_PTS - 1)) begin
                        last_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        next_bin_s = 1'b1;
                        clr_s      = 1'b1;
                        state_s    = COMPUTE;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Handshake/status flags registered from the next state so they align with state_r.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == LOAD);
            busy_r      <= (state_s != IDLE);
            out_valid_r <= (state_s == OUT);
            done_r      <= last_s;
        end
    end

    // Sample counter and latched offset for the frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            offset_r <= {ACC_W{1'b0}};
        end else if (start_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            offset_r <= offset;
        end else if (load_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            offset_r <= offset_r;
        end else begin
            cnt_r    <= cnt_r;
            offset_r <= offset_r;
        end
    end

    // Sample store; contents are don't-care across reset.
    always_ff @(posedge clk) begin
        if (load_s) begin
            samples_r[cnt_r] <= in_data;
        end
    end

    // Bit and bin indices walking the ROM network.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_r <= {BIT_W{1'b0}};
            bin_r <= {BIN_W{1'b0}};
        end else begin
            if (clr_s) begin
                bit_r <= {BIT_W{1'b0}};
            end else if (step_s) begin
                bit_r <= bit_r + BIT_W'(1);
            end else begin
                bit_r <= bit_r;
            end
            if (start_s || first_s) begin
                bin_r <= {BIN_W{1'b0}};
            end else if (next_bin_s) begin
                bin_r <= bin_r + 4'd1;
            end else begin
                bin_r <= bin_r;
            end
        end
    end

    // Bin tag captured alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_bin_r <= {BIN_W{1'b0}};
        end else if (fin_s) begin
            out_bin_r <= bin_r;
        end else begin
            out_bin_r <= out_bin_r;
        end
    end

    // Bit-slice address: one bit from every stored sample, quiet outside COMPUTE.
    always_comb begin
        slice_s = {N_PTS{1'b0}};
        if (state_r == COMPUTE) begin
            for (int i = 0; i < N_PTS; i++) begin
                slice_s[i] = samples_r[i][bit_r];
            end
        end else begin
            slice_s = {N_PTS{1'b0}};
        end
    end

    obc_shift_acc #(
        .ACC_W(ACC_W)
    ) u_shift_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .step    (step_s),
        .fin     (fin_s),
        .rom_sum (rom_sum),
        .offset  (offset_r),
        .out_data(out_data)
    );

    assign slice     = slice_s;
    assign bin_idx   = bin_r;
    assign out_bin   = out_bin_r;
    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_obc_dft_sequencer.sv
// Directed, table-driven bench for obc_dft_sequencer with a behavioural ROM network.
module tb_obc_dft_sequencer;

    localparam int SAMP_W = 12;
    localparam int N_PTS  = 16;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ACC_W-1:0]  offset;
    logic              in_valid;
    logic              in_ready;
    logic [SAMP_W-1:0] in_data;
    logic [N_PTS-1:0]  slice;
    logic [3:0]        bin_idx;
    logic [ACC_W-1:0]  rom_sum;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic [3:0]        out_bin;
    logic              busy;
    logic              done;

    obc_dft_sequencer #(.SAMP_W(SAMP_W), .N_PTS(N_PTS), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .offset(offset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .slice(slice), .bin_idx(bin_idx), .rom_sum(rom_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bin(out_bin), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rom_sel;   // 0: constant rom_val, 1: slice-dependent model
        logic [31:0] rom_val;
        logic [31:0] offs;
        logic [11:0] x0;
        logic [11:0] xo;
        logic        gap;
        logic        noise;
        int          stall;
        logic        smid;
        int          rst_bin;   // 16 = no reset
        logic [31:0] exp_base;
        logic [31:0] exp_step;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    logic        rom_sel_r = 1'b0;
    logic [31:0] rom_val_r = 32'd0;

    // ROM network: slice 0x0001 yields (bin+1)<<16, all-zero slice yields 0, anything else garbage.
    always_comb begin
        if (rom_sel_r) begin
            if (slice == 16'h0001)      rom_sum = ({28'd0, bin_idx} + 32'd1) << 16;
            else if (slice == 16'h0000) rom_sum = 32'd0;
            else                        rom_sum = 32'h1234_5678;
        end else begin
            rom_sum = rom_val_r;
        end
    end

    int          k = 0;
    logic [15:0] mask = 16'd0;
    int          bad = 0;
    int          leak = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy && !in_ready && !out_valid) begin
            if (k == 0) begin
                mask = 16'd0;
                bad  = 0;
            end
            if (slice == 16'h0001) begin
                if (k < 16) mask[k] = 1'b1;
            end else if (slice != 16'h0000) begin
                bad++;
            end
            k++;
        end else begin
            k = 0;
            if (slice != 16'h0000) leak++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_slice"}, 32'(slice), 32'd0);
        chk({tag, "_bin_idx"}, 32'(bin_idx), 32'd0);
        chk({tag, "_out_bin"}, 32'(out_bin), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
    endtask

    task automatic run_frame(input vec_t v);
        int          i;
        int          cyc;
        int          lat;
        logic [31:0] exp;
        logic [31:0] held;
        rom_sel_r = v.rom_sel;
        rom_val_r = v.rom_val;
        cyc = 0;
        while ((busy || done) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        start  = 1'b1;
        offset = v.offs;
        i   = 0;
        cyc = 0;
        while (i < 16 && cyc < 200) begin
            @(negedge clk);
            start  = 1'b0;
            offset = 32'hCAFE_F00D;
            cyc++;
            if (in_ready && !(v.gap && (cyc % 3 == 0))) begin
                in_valid = 1'b1;
                in_data  = (i == 0) ? v.x0 : v.xo;
                i++;
            end else begin
                in_valid = 1'b0;
                in_data  = 12'hABC;
            end
        end
        chk("load_count", 32'(i), 32'd16);
        for (int b = 0; b < 16; b++) begin
            if (b == v.rst_bin) begin
                @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                chk("busy_before_rst", 32'(busy), 32'd1);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_reset_outputs("midframe_rst");
                in_valid = 1'b0;
                return;
            end
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
                out_ready = 1'b0;
                in_valid  = v.noise;
                in_data   = 12'hFFF;
                if (v.smid && b == 0) start = (lat == 5);
            end while (!out_valid && lat < 60);
            start = 1'b0;
            chk("latency", 32'(lat), 32'd13);
            chk("out_bin", 32'(out_bin), 32'(b));
            exp = v.exp_base + v.exp_step * 32'(b);
            chk("out_data", out_data, exp);
            if (v.rom_sel) begin
                chk("slice_mask", 32'(mask), 32'h0000_0801);
                chk("slice_bad", 32'(bad), 32'd0);
            end
            held = out_data;
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, held);
                chk("stall_bin", 32'(out_bin), 32'(b));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("idle_at_done", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_cleared", 32'(done), 32'd0);
        chk("start_with_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        int frames;
        vecs[0] = '{1'b0, 32'h0020_0000, 32'h0000_0000, 12'h5A5, 12'h3C3, 1'b0, 1'b0, 0, 1'b0, 16, 32'hFFFF_FC00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0010_0000, 12'h7FF, 12'h800, 1'b0, 1'b0, 0, 1'b0, 16, 32'h0010_0000, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 12'h801, 12'h000, 1'b1, 1'b1, 0, 1'b1, 16, 32'hFFFF_0020, 32'hFFFF_0020};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 12'hFFF, 12'h001, 1'b0, 1'b0, 0, 1'b0, 16, 32'h0010_0000, 32'h0};
        vecs[4] = '{1'b0, 32'h0020_0000, 32'h8000_0000, 12'h123, 12'h456, 1'b0, 1'b0, 2, 1'b0, 16, 32'h7FFF_FC00, 32'h0};
        vecs[5] = '{1'b0, 32'h0020_0000, 32'h0000_0400, 12'h0F0, 12'hF0F, 1'b0, 1'b0, 5, 1'b0, 16, 32'h0000_0000, 32'h0};
        vecs[6] = '{1'b0, 32'h0020_0000, 32'h0000_0000, 12'h555, 12'hAAA, 1'b0, 1'b0, 0, 1'b0, 7,  32'hFFFF_FC00, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0000, 32'h0000_0040, 12'h801, 12'h000, 1'b0, 1'b0, 0, 1'b0, 16, 32'hFFFF_0060, 32'hFFFF_0020};

        rst_n     = 1'b0;
        start     = 1'b0;
        offset    = 32'd0;
        in_valid  = 1'b0;
        in_data   = 12'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        frames = 0;
        for (int r = 0; r < 8; r++) begin
            run_frame(vecs[r]);
            if (vecs[r].rst_bin == 16) frames++;
        end

        repeat (2) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(frames));
        chk("slice_outside_compute", 32'(leak), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obc_dft_sequencer.md
OBC_DFT_SEQUENCER -- requirements
Module: obc_dft_sequencer

Interface
REQ-001 SHALL have one parameter per line as name, default, meaning: SAMP_W, 12, input sample width in two's complement; N_PTS, 16, samples and bins per frame; ACC_W, 32, accumulator and ROM word width in Q10.21 with 1 sign, 10 integer and 21 fraction bits.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning (clock and reset first):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous active-low reset
  start  in  1  begin frame; honoured only in IDLE
  offset  in  ACC_W  OBC initial-offset word; sampled when start is accepted
  in_valid  in  1  sample valid
  in_ready  out  1  high only in LOAD
  in_data  in  SAMP_W  sample, order x0..x15
  slice  out  N_PTS  bit-slice address to ROM network; slice[i] = sample i bit bit_idx
  bin_idx  out  4  DFT bin selecting the ROM bank
  rom_sum  in  ACC_W  combinational ROM-network partial sum for (slice, bin_idx)
  out_valid  out  1  result valid
  out_ready  in  1  downstream accept
  out_data  out  ACC_W  bin result
  out_bin  out  4  bin of out_data
  busy  out  1  high when not IDLE
  done  out  1  one-cycle pulse after bin 15 is accepted

Function
REQ-003 SHALL implement states IDLE, LOAD, COMPUTE and OUT.
REQ-004 SHALL, in IDLE with start=1, latch offset, clear the sample count and enter LOAD; start SHALL be ignored in every other state.
REQ-005 SHALL, in LOAD, store in_data at index cnt on each cycle with in_valid&in_ready; on index 15 it SHALL set bin_idx=0, bit_idx=0, acc=0 and enter COMPUTE on the next cycle.
REQ-006 SHALL, in COMPUTE, drive slice from bit_idx and take rom_sum in the same cycle, with no ROM latency.
REQ-007 SHALL, for bit_idx 0..SAMP_W-2, set acc <= arithmetic-shift-right-by-1 of the sign-extended (ACC_W+1)-bit sum (acc + rom_sum), keeping the low ACC_W bits.
REQ-008 SHALL, at bit_idx = SAMP_W-1 (MSB), load out_data <= acc - rom_sum + offset_reg modulo 2^ACC_W, set out_bin=bin_idx and enter OUT.
REQ-009 SHALL make each bin take exactly SAMP_W COMPUTE cycles, with out_valid rising the cycle after the MSB cycle.
REQ-010 SHALL, in OUT, hold out_valid, out_data and out_bin stable until out_ready=1.
REQ-011 SHALL, on acceptance in OUT, go to COMPUTE with bin_idx+1, bit_idx=0 and acc=0 if bin_idx<15; otherwise it SHALL go to IDLE and pulse done for one cycle.
REQ-012 SHALL drive slice=0 outside COMPUTE.
REQ-013 SHALL give no simultaneous accept and new-frame overlap: start arriving with done is ignored and is honoured only from the following IDLE cycle.
REQ-014 SHALL ignore in_valid outside LOAD.
REQ-015 SHALL wrap on arithmetic overflow with no saturation or flag.

Reset
REQ-016 SHALL, with rst_n=0 at a clock edge, go to IDLE with in_ready=0, out_valid=0, done=0, busy=0, slice=0, bin_idx=0, out_bin=0, out_data=0, acc=0 and offset_reg=0.
REQ-017 SHALL let reset mid-LOAD, mid-COMPUTE or mid-OUT abandon the frame with no result emitted; stored samples need not be cleared.

Structure
REQ-018 SHALL keep SAMP_W, N_PTS, ACC_W defaults and the state enum in shared package obc_dft_pkg.
REQ-019 SHALL place the shift-accumulate datapath (REQ-007/008 arithmetic) in sub-module obc_shift_acc, with the FSM in obc_dft_sequencer.
REQ-020 SHALL keep the ROM network outside this block.

Verification
REQ-021 SHALL cover: constant rom_sum=0x00200000, offset=0, any samples -> every bin out_data=0xFFFFFC00, bins 0..15 in order, done once.
REQ-022 SHALL cover: rom_sum=0, offset=0x00100000 -> all 16 results 0x00100000.
REQ-023 SHALL cover: x0=0x801, others 0, rom_sum model = slice-dependent -> slice=0x0001 seen at bit_idx 0 and 11 only; out_data matches the reference model.
REQ-024 SHALL cover: out_ready held low 5 cycles in OUT -> out_valid/out_data stable; the next bin starts the cycle after the accept.
REQ-025 SHALL cover: in_valid gapped during LOAD and start pulsed mid-COMPUTE -> only valid beats stored and start ignored; latency from 16th sample to first out_valid = 13 cycles.
REQ-026 SHALL cover: rst_n low during bin 7 COMPUTE -> next cycle IDLE with all outputs at reset values; a new frame completes correctly.
